led_shift_array: RTL and testbench

- Consumes the `tiks` square wave from the tick generator and advances an LED pattern one position per step.
- Supports rotate-left, rotate-right, bounce and hold modes, plus a synchronous pattern load.
- Drives the board LED pins directly and emits a one-cycle `step_pulse` for downstream observers.

---
 rtl/led_shift_array_pkg.sv | 18 +
 rtl/led_shift_array_if.sv | 23 ++
 rtl/led_shift_array_tick_step_div.sv | 37 +++
 rtl/led_shift_array.sv | 95 +++++++++
 tb/tb_led_shift_array.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/led_shift_array_pkg.sv
// Shared mode codes, direction codes and FSM state type for the LED shifter.
package led_shift_pkg;

   localparam logic [1:0] MODE_ROT_L  = 2'b00;
   localparam logic [1:0] MODE_ROT_R  = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Direction FSM state; encoding equals the dir output value.
   typedef enum logic {
      ST_LEFT  = DIR_LEFT,
      ST_RIGHT = DIR_RIGHT
   } dir_state_t;

endpackage

// File: rtl/led_shift_array_if.sv
// Control/pattern bundle between the LED shifter and whoever drives it.
interface led_shift_array_if #(
   parameter int WIDTH = 8
);
   logic             tiks;
   logic             enable;
   logic [1:0]       mode;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] leds;
   logic             dir;
   logic             step_pulse;

   modport master (
      output tiks, enable, mode, load, load_data,
      input  leds, dir, step_pulse
   );

   modport slave (
      input  tiks, enable, mode, load, load_data,
      output leds, dir, step_pulse
   );
endinterface

// File: rtl/led_shift_array_tick_step_div.sv
// Rising-edge detector on the tiks square wave plus a step divider.
// step_evt is combinational: it marks the cycle whose clock edge commits a step.
module tick_step_div #(
   parameter int STEP_DIV = 1
) (
   input  logic clock,
   input  logic rst,
   input  logic tiks,
   input  logic advance_en,
   input  logic clr,
   output logic step_evt
);
   localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic          tiks_q;
   logic [CW-1:0] div_cnt;
   logic          tick_evt;
   logic          adv;

   assign tick_evt = tiks & ~tiks_q;
   assign adv      = tick_evt & advance_en;
   assign step_evt = adv & (div_cnt == LAST);

   // Previous tiks sample; forced high in reset so a high tiks at release is not an edge.
   always_ff @(posedge clock) begin
      if (rst) tiks_q <= 1'b1;
      else     tiks_q <= tiks;
   end

   // Divider counts qualified ticks and wraps on the step tick; frozen when not enabled.
   always_ff @(posedge clock) begin
      if (rst || clr)  div_cnt <= '0;
      else if (adv)    div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
   end

endmodule

// File: rtl/led_shift_array.sv
// LED pattern shifter: rotate left/right, bounce or hold, advanced by divided
// tiks rising edges, with a synchronous pattern load that overrides a step.
module led_shift_array
   import led_shift_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter int               STEP_DIV      = 1,
   parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input logic               clock,
   input logic               rst,
   led_shift_array_if.slave  bus
);

   dir_state_t       state, state_nxt;
   logic [WIDTH-1:0] leds_q, leds_nxt;
   logic             pulse_q, pulse_nxt;
   logic             step_evt;
   logic             advance_en;
   logic [WIDTH-1:0] rol, ror;

   // Hold mode generates no steps and freezes the divider, same as enable=0.
   assign advance_en = bus.enable && (bus.mode != MODE_HOLD);

   tick_step_div #(.STEP_DIV(STEP_DIV)) u_div (
      .clock      (clock),
      .rst        (rst),
      .tiks       (bus.tiks),
      .advance_en (advance_en),
      .clr        (bus.load),
      .step_evt   (step_evt)
   );

   assign rol = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
   assign ror = {leds_q[0], leds_q[WIDTH-1:1]};

   // Next pattern/direction: load beats step; bounce reverses when the lit end is reached.
   always_comb begin
      state_nxt = state;
      leds_nxt  = leds_q;
      pulse_nxt = 1'b0;
      if (bus.load) begin
         leds_nxt  = bus.load_data;
         state_nxt = ST_LEFT;
      end else if (step_evt) begin
         pulse_nxt = 1'b1;
         case (bus.mode)
            MODE_ROT_L: begin
               leds_nxt  = rol;
               state_nxt = ST_LEFT;
            end
            MODE_ROT_R: begin
               leds_nxt  = ror;
               state_nxt = ST_RIGHT;
            end
            MODE_BOUNCE: begin
               if (state == ST_LEFT) begin
                  if (leds_q[WIDTH-1]) begin
                     state_nxt = ST_RIGHT;
                     leds_nxt  = ror;
                  end else begin
                     leds_nxt  = rol;
                  end
               end else begin
                  if (leds_q[0]) begin
                     state_nxt = ST_LEFT;
                     leds_nxt  = rol;
                  end else begin
                     leds_nxt  = ror;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Pattern, direction state and step pulse registers.
   always_ff @(posedge clock) begin
      if (rst) begin
         leds_q  <= RESET_PATTERN;
         state   <= ST_LEFT;
         pulse_q <= 1'b0;
      end else begin
         leds_q  <= leds_nxt;
         state   <= state_nxt;
         pulse_q <= pulse_nxt;
      end
   end

   assign bus.leds       = leds_q;
   assign bus.dir        = (state == ST_RIGHT);
   assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_led_shift_array.sv
// Directed bench: two shifters (STEP_DIV=1 and STEP_DIV=2) share one stimulus;
// tiks is held 4 clocks high / 4 clocks low around each rising edge.
module tb_led_shift_array;
   import led_shift_pkg::*;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       tiks = 1'b0;
   logic       enable = 1'b0;
   logic       load = 1'b0;
   logic [1:0] mode = MODE_ROT_L;
   logic [7:0] load_data = 8'h00;

   int checks = 0;
   int errors = 0;
   int pc_a = 0;
   int pc_b = 0;
   int p0;

   always #5 clock = ~clock;

   led_shift_array_if #(.WIDTH(8)) ifa ();
   led_shift_array_if #(.WIDTH(8)) ifb ();

   assign ifa.tiks = tiks;  assign ifa.enable = enable;  assign ifa.mode = mode;
   assign ifa.load = load;  assign ifa.load_data = load_data;
   assign ifb.tiks = tiks;  assign ifb.enable = enable;  assign ifb.mode = mode;
   assign ifb.load = load;  assign ifb.load_data = load_data;

   led_shift_array #(.WIDTH(8), .STEP_DIV(1), .RESET_PATTERN(8'h01)) dut_a (
      .clock(clock), .rst(rst), .bus(ifa));
   led_shift_array #(.WIDTH(8), .STEP_DIV(2), .RESET_PATTERN(8'h01)) dut_b (
      .clock(clock), .rst(rst), .bus(ifb));

   // Count step pulse cycles of each instance.
   always @(negedge clock) begin
      if (ifa.step_pulse === 1'b1) pc_a <= pc_a + 1;
      if (ifb.step_pulse === 1'b1) pc_b <= pc_b + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Raise tiks; return at the negedge right after the edge that samples it.
   task automatic rise();
      @(negedge clock) tiks = 1'b1;
      @(negedge clock);
   endtask

   // Finish the high phase and spend 4 clocks low.
   task automatic fall();
      repeat (3) @(negedge clock);
      tiks = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic step_a(input string tag, input logic [7:0] el, input logic ed, input logic ep);
      rise();
      chk({tag, "_leds"}, 32'(ifa.leds), 32'(el));
      chk({tag, "_dir"}, 32'(ifa.dir), 32'(ed));
      chk({tag, "_pulse"}, 32'(ifa.step_pulse), 32'(ep));
      fall();
   endtask

   task automatic step_b(input string tag, input logic [7:0] el, input logic ep);
      rise();
      chk({tag, "_leds"}, 32'(ifb.leds), 32'(el));
      chk({tag, "_pulse"}, 32'(ifb.step_pulse), 32'(ep));
      fall();
   endtask

   logic [7:0] rotl_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
   logic [7:0] bnc_exp  [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
   logic       bnc_dir  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      // 1: reset held 3 cycles while tiks toggles, released with tiks high
      rst = 1'b1; tiks = 1'b0; mode = MODE_ROT_L; enable = 1'b1;
      @(negedge clock) tiks = 1'b1;
      @(negedge clock) tiks = 1'b0;
      @(negedge clock) tiks = 1'b1;
      chk("rst_leds", 32'(ifa.leds), 32'h01);
      chk("rst_dir", 32'(ifa.dir), 32'h0);
      chk("rst_pulse", 32'(ifa.step_pulse), 32'h0);
      p0 = pc_a;
      rst = 1'b0;
      repeat (4) @(negedge clock);
      chk("rel_leds", 32'(ifa.leds), 32'h01);
      chk("rel_npulse", 32'(pc_a - p0), 32'd0);
      tiks = 1'b0;
      repeat (4) @(negedge clock);

      // 2: rotate left, one step per tiks edge
      p0 = pc_a;
      for (int i = 0; i < 8; i++) step_a("rotl", rotl_exp[i], 1'b0, 1'b1);
      chk("rotl_npulse", 32'(pc_a - p0), 32'd8);

      // 3: rotate right from 01, then hold
      mode = MODE_ROT_R;
      step_a("rotr0", 8'h80, 1'b1, 1'b1);
      step_a("rotr1", 8'h40, 1'b1, 1'b1);
      mode = MODE_HOLD;
      step_a("hold", 8'h40, 1'b1, 1'b0);

      // 4: load 40 then bounce
      @(negedge clock) begin load = 1'b1; load_data = 8'h40; end
      @(negedge clock) load = 1'b0;
      chk("ld40_leds", 32'(ifa.leds), 32'h40);
      chk("ld40_dir", 32'(ifa.dir), 32'h0);
      mode = MODE_BOUNCE;
      for (int i = 0; i < 9; i++) step_a("bnc", bnc_exp[i], bnc_dir[i], 1'b1);

      // 6: load coincident with a step edge wins, then reset mid-run
      mode = MODE_ROT_L;
      @(negedge clock) begin tiks = 1'b1; load = 1'b1; load_data = 8'hA5; end
      @(negedge clock) load = 1'b0;
      chk("ldstep_leds", 32'(ifa.leds), 32'hA5);
      chk("ldstep_pulse", 32'(ifa.step_pulse), 32'h0);
      fall();
      mode = MODE_ROT_R;
      step_a("a5_rotr", 8'hD2, 1'b1, 1'b1);
      @(negedge clock) begin rst = 1'b1; tiks = 1'b1; end
      @(negedge clock) rst = 1'b0;
      chk("mrst_leds", 32'(ifa.leds), 32'h01);
      chk("mrst_dir", 32'(ifa.dir), 32'h0);
      chk("mrst_pulse", 32'(ifa.step_pulse), 32'h0);
      fall();
      chk("mrst_hold", 32'(ifa.leds), 32'h01);

      // 5: STEP_DIV=2 instance, divider freeze while disabled
      mode = MODE_ROT_L; enable = 1'b1;
      p0 = pc_b;
      step_b("d2_e1", 8'h01, 1'b0);
      step_b("d2_e2", 8'h02, 1'b1);
      step_b("d2_e3", 8'h02, 1'b0);
      step_b("d2_e4", 8'h04, 1'b1);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) step_b("d2_dis", 8'h04, 1'b0);
      enable = 1'b1;
      step_b("d2_e5", 8'h04, 1'b0);
      step_b("d2_e6", 8'h08, 1'b1);
      chk("d2_npulse", 32'(pc_b - p0), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
